alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters: requester 0 is the EX stage and requester 1 is the load/store address generator.
- Arbitrates between the requesters and registers the winning operation into an issue register.
- Drives the ALU from that register for one cycle, then captures the ALU result and zero flag into a per-requester response, held until the requester accepts it.
- Sits between decode/issue logic and the ALU; the ALU itself remains outside this block.

Parameters:
- XLEN, 32, datapath width of operands and result.
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority to requester 0.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_aluop  in  2x2  ALUOp per requester: 00 add, 01 branch compare, 10 R/I-type, 11 illegal.
- req_instr  in  2x32  instruction word per requester; funct3 is bits 14:12, bit 30 selects add/sub and SRL/SRA.
- req_a, req_b  in  2xXLEN  operand 1 and operand 2 per requester.
- req_imm  in  2  immediate-form flag per requester.
- resp_valid  out  2  response valid per requester.
- resp_ready  in  2  response accepted per requester.
- resp_result  out  XLEN  shared result bus; meaningful only for the requester whose resp_valid is high.
- resp_zero  out  1  branch-taken flag.
- resp_err  out  1  illegal ALUOp flag.
- alu_op, alu_instr, alu_data1, alu_data2, alu_imm  out  2/32/XLEN/XLEN/1  drive the shared ALU.
- alu_result  in  XLEN  result returned by the ALU.
- alu_zero  in  1  compare outcome returned by the ALU.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  index of the requester owning the current operation.

Behaviour:
- Reset: all outputs are 0, state = IDLE, last_grant = 1 (so requester 0 wins the first tie), and the issue and response registers are cleared.
- Reset mid-operation: any in-flight operation or pending response is dropped with no resp_valid pulse; the requester must re-issue.
- State machine states: IDLE, EXEC, RESP.
- IDLE, grant selection: req_ready is a combinational function of the state, req_valid and last_grant, and asserts for at most one requester.
- IDLE, round-robin (PRIO_MODE=0): if both requesters are valid, grant the one that is not last_grant.
- IDLE, fixed priority (PRIO_MODE=1): requester 0 always wins.
- IDLE, handshake: on req_valid[g] & req_ready[g], capture aluop, instr, a, b and imm into the issue register.
- IDLE, bookkeeping on handshake: grant_id <= g, last_grant <= g, then go to EXEC.
- IDLE, no request: stay in IDLE.
- EXEC (exactly one cycle), ALU drive: the alu_* outputs are driven from the issue register.
- EXEC, capture: at the end of the cycle, the response register captures the ALU outputs, then go to RESP.
- EXEC, result masking by ALUOp:
  - 00/10: resp_result = alu_result, resp_zero = 0.
  - 01: resp_result = 0, resp_zero = alu_zero.
  - 11: the ALU is not driven (alu_op = 00, alu_data1/alu_data2 = 0, alu_instr = 0); resp_result = 0, resp_zero = 0, resp_err = 1.
- Outside EXEC: all alu_* outputs are 0.
- RESP: resp_valid[grant_id] = 1 and all response fields are held stable; req_ready = 0.
- RESP exit: on resp_ready[grant_id], go to IDLE next cycle.
- RESP hold: resp_ready on the non-granted bit is ignored.
- Latency: handshake at edge N, resp_valid high from the cycle after edge N+1, i.e. 2 cycles.
- Throughput: at most one operation per 3 cycles (IDLE, EXEC, RESP).
- Request-side stability: requesters hold req_* stable while req_valid is high and not yet accepted; the block does not check this.
- Simultaneous events: a new request that arrives while busy waits in IDLE on the next return; no request is lost.
- Round-robin fairness: with both requesters valid continuously, grants alternate 0,1,0,1 in mode 0; in mode 1 requester 1 is starved (documented, intended).
- Width rules: no arithmetic is performed in this block; signedness, shift amount and sub/add selection remain in the ALU.

Decomposition:
- Shared package riscv_pkg:
  - ALUOp encodings ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_RI=2'b10, ALUOP_ILL=2'b11.
  - State encodings for IDLE, EXEC, RESP.
  - XLEN default.
- Sub-module rr_arb2: a 2-input round-robin/fixed-priority grant generator taking valid[1:0], last_grant and mode, and producing a one-hot grant.
- The FSM and the issue and response registers stay in the top module.

Test Plan:
- After reset, req 0 only: aluop=10, instr funct3=000, bit30=1, a=10, b=3.
  - req_ready[0] is 1 in the request cycle.
  - alu_data1=10, alu_data2=3 in EXEC.
  - resp_valid[0] is high 2 cycles after acceptance with resp_result=7 (bench ALU model subtracts).
  - resp_zero=0.
- Both requesters valid continuously for 4 operations, PRIO_MODE=0, resp_ready tied high:
  - grant_id sequence is 0,1,0,1.
  - Each operation takes 3 cycles.
  - The non-granted req_ready stays 0.
- Same stimulus with PRIO_MODE=1: grant_id is 0,0,0,0 and req_ready[1] is never asserted.
- Branch op: aluop=01, funct3=000, a=b=5.
  - resp_zero=1 and resp_result=0.
  - With a=5, b=6: resp_zero=0.
- Illegal aluop=11:
  - The alu_* outputs stay 0 in EXEC.
  - resp_err=1 and resp_result=0.
  - Back-pressure: resp_ready held 0 for 5 cycles keeps resp_valid and the response fields stable with busy=1; releasing it returns to IDLE next cycle.
- rst asserted during EXEC:
  - Next cycle resp_valid=0, busy=0 and all outputs are 0.
  - No response is emitted for the dropped operation.
  - A subsequent request from requester 0 wins (last_grant=1).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the ALU share arbiter: ALUOp codes, FSM states and
// the control half of the issue register.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int ILEN         = 32;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_RI  = 2'b10;
   localparam logic [1:0] ALUOP_ILL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [1:0]      aluop;
      logic [ILEN-1:0] instr;
      logic            imm;
   } issue_ctl_t;

   function automatic logic aluop_drives_alu(input logic [1:0] op);
      return op != ALUOP_ILL;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
// The master side is the requester pair, the slave side is the arbiter.
interface alu_share_arbiter_if #(
   parameter int XLEN = 32
);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][1:0]       req_aluop;
   logic [1:0][31:0]      req_instr;
   logic [1:0][XLEN-1:0]  req_a;
   logic [1:0][XLEN-1:0]  req_b;
   logic [1:0]            req_imm;

   logic [1:0]            resp_valid;
   logic [1:0]            resp_ready;
   logic [XLEN-1:0]       resp_result;
   logic                  resp_zero;
   logic                  resp_err;

   modport master (
      output req_valid, req_aluop, req_instr, req_a, req_b, req_imm, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_zero, resp_err
   );

   modport slave (
      input  req_valid, req_aluop, req_instr, req_a, req_b, req_imm, resp_ready,
      output req_ready, resp_valid, resp_result, resp_zero, resp_err
   );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-input grant generator: round-robin on last_grant (mode 0) or fixed
// priority to input 0 (mode 1). Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       mode,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid == 2'b11) begin
         // on a tie, input 0 wins unless it was served last (round-robin)
         grant = (mode || last_grant) ? 2'b01 : 2'b10;
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the EX stage (req 0) and the
// load/store AGU (req 1): arbitrate, issue for one cycle, hold the response.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for a request; req_ready reflects the arbiter grant
//  EXEC    | ALU driven from the issue register; response captured at edge
//  RESP    | resp_valid[grant_id] held until that requester accepts
module alu_share_arbiter
   import riscv_pkg::*;
#(
   parameter int XLEN      = XLEN_DEFAULT,
   parameter bit PRIO_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   alu_share_arbiter_if.slave bus,
   output logic [1:0]       alu_op,
   output logic [ILEN-1:0]  alu_instr,
   output logic [XLEN-1:0]  alu_data1,
   output logic [XLEN-1:0]  alu_data2,
   output logic             alu_imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             alu_zero,
   output logic             busy,
   output logic             grant_id
);

   state_e          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            grant_id_q, grant_id_d;
   issue_ctl_t      iss_ctl_q, iss_ctl_d;
   logic [XLEN-1:0] iss_a_q, iss_a_d;
   logic [XLEN-1:0] iss_b_q, iss_b_d;
   logic [XLEN-1:0] rsp_result_q, rsp_result_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic            rsp_err_q, rsp_err_d;

   logic [1:0]      arb_grant;
   logic            arb_idx;
   logic [1:0]      req_ready;
   logic [1:0]      resp_valid;

   rr_arb2 u_arb (
      .valid      (bus.req_valid),
      .last_grant (last_grant_q),
      .mode       (PRIO_MODE),
      .grant      (arb_grant)
   );

   assign arb_idx = arb_grant[1];

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      iss_ctl_d    = iss_ctl_q;
      iss_a_d      = iss_a_q;
      iss_b_d      = iss_b_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      req_ready    = 2'b00;
      resp_valid   = 2'b00;
      alu_op       = 2'b00;
      alu_instr    = '0;
      alu_data1    = '0;
      alu_data2    = '0;
      alu_imm      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = arb_grant;
            if (arb_grant != 2'b00) begin
               iss_ctl_d.aluop = bus.req_aluop[arb_idx];
               iss_ctl_d.instr = bus.req_instr[arb_idx];
               iss_ctl_d.imm   = bus.req_imm[arb_idx];
               iss_a_d         = bus.req_a[arb_idx];
               iss_b_d         = bus.req_b[arb_idx];
               grant_id_d      = arb_idx;
               last_grant_d    = arb_idx;
               state_d         = ST_EXEC;
            end
         end

         ST_EXEC: begin
            // an illegal op never reaches the ALU; it only raises resp_err
            if (aluop_drives_alu(iss_ctl_q.aluop)) begin
               alu_op    = iss_ctl_q.aluop;
               alu_instr = iss_ctl_q.instr;
               alu_data1 = iss_a_q;
               alu_data2 = iss_b_q;
               alu_imm   = iss_ctl_q.imm;
            end
            case (iss_ctl_q.aluop)
               ALUOP_ADD, ALUOP_RI: begin
                  rsp_result_d = alu_result;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 1'b0;
               end
               ALUOP_BR: begin
                  rsp_result_d = '0;
                  rsp_zero_d   = alu_zero;
                  rsp_err_d    = 1'b0;
               end
               default: begin
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 1'b1;
               end
            endcase
            state_d = ST_RESP;
         end

         ST_RESP: begin
            resp_valid[grant_id_q] = 1'b1;
            if (bus.resp_ready[grant_id_q]) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         iss_ctl_q    <= '0;
         iss_a_q      <= '0;
         iss_b_q      <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         iss_ctl_q    <= iss_ctl_d;
         iss_a_q      <= iss_a_d;
         iss_b_q      <= iss_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.req_ready   = req_ready;
   assign bus.resp_valid  = resp_valid;
   assign bus.resp_result = rsp_result_q;
   assign bus.resp_zero   = rsp_zero_q;
   assign bus.resp_err    = rsp_err_q;
   assign busy            = (state_q != ST_IDLE);
   assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: one round-robin and one fixed-priority
// instance, each driven with directed and random operations.
module tb_alu_share_arbiter;

   localparam int XLEN = 32;

   typedef struct {
      logic [1:0]      aluop;
      logic [31:0]     ins;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic            imm;
   } op_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int last_g [2];

   logic [1:0]            v_valid  [2];
   logic [1:0]            v_rready [2];
   logic [1:0][1:0]       v_aluop  [2];
   logic [1:0][31:0]      v_instr  [2];
   logic [1:0][XLEN-1:0]  v_a      [2];
   logic [1:0][XLEN-1:0]  v_b      [2];
   logic [1:0]            v_imm    [2];

   logic [1:0]      o_req_ready  [2];
   logic [1:0]      o_resp_valid [2];
   logic [XLEN-1:0] o_result     [2];
   logic            o_zero       [2];
   logic            o_err        [2];
   logic [1:0]      alu_op       [2];
   logic [31:0]     alu_instr    [2];
   logic [XLEN-1:0] alu_d1       [2];
   logic [XLEN-1:0] alu_d2       [2];
   logic            alu_imm      [2];
   logic [XLEN-1:0] alu_result   [2];
   logic            alu_zero     [2];
   logic            busy_w       [2];
   logic            gid_w        [2];

   alu_share_arbiter_if #(.XLEN(XLEN)) bus0 ();
   alu_share_arbiter_if #(.XLEN(XLEN)) bus1 ();

   assign bus0.req_valid  = v_valid[0];  assign bus1.req_valid  = v_valid[1];
   assign bus0.resp_ready = v_rready[0]; assign bus1.resp_ready = v_rready[1];
   assign bus0.req_aluop  = v_aluop[0];  assign bus1.req_aluop  = v_aluop[1];
   assign bus0.req_instr  = v_instr[0];  assign bus1.req_instr  = v_instr[1];
   assign bus0.req_a      = v_a[0];      assign bus1.req_a      = v_a[1];
   assign bus0.req_b      = v_b[0];      assign bus1.req_b      = v_b[1];
   assign bus0.req_imm    = v_imm[0];    assign bus1.req_imm    = v_imm[1];

   assign o_req_ready[0]  = bus0.req_ready;   assign o_req_ready[1]  = bus1.req_ready;
   assign o_resp_valid[0] = bus0.resp_valid;  assign o_resp_valid[1] = bus1.resp_valid;
   assign o_result[0]     = bus0.resp_result; assign o_result[1]     = bus1.resp_result;
   assign o_zero[0]       = bus0.resp_zero;   assign o_zero[1]       = bus1.resp_zero;
   assign o_err[0]        = bus0.resp_err;    assign o_err[1]        = bus1.resp_err;

   alu_share_arbiter #(.XLEN(XLEN), .PRIO_MODE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0),
      .alu_op(alu_op[0]), .alu_instr(alu_instr[0]), .alu_data1(alu_d1[0]),
      .alu_data2(alu_d2[0]), .alu_imm(alu_imm[0]),
      .alu_result(alu_result[0]), .alu_zero(alu_zero[0]),
      .busy(busy_w[0]), .grant_id(gid_w[0])
   );

   alu_share_arbiter #(.XLEN(XLEN), .PRIO_MODE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .alu_op(alu_op[1]), .alu_instr(alu_instr[1]), .alu_data1(alu_d1[1]),
      .alu_data2(alu_d2[1]), .alu_imm(alu_imm[1]),
      .alu_result(alu_result[1]), .alu_zero(alu_zero[1]),
      .busy(busy_w[1]), .grant_id(gid_w[1])
   );

   // Behavioural RV32 ALU: branch ops also produce a difference and
   // arithmetic ops also produce a zero flag, so the arbiter's masking matters.
   function automatic logic [XLEN:0] alu_model(input logic [1:0] op, input logic [31:0] ins,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                               input logic imm);
      logic [2:0]      f3;
      logic [XLEN-1:0] r;
      logic            z;
      int              sh;
      f3 = ins[14:12];
      sh = int'(b[4:0]);
      r  = a + b;
      z  = 1'b0;
      case (op)
         2'b01: begin
            r = a - b;
            case (f3)
               3'd0: z = (a == b);
               3'd1: z = (a != b);
               3'd4: z = ($signed(a) <  $signed(b));
               3'd5: z = ($signed(a) >= $signed(b));
               3'd6: z = (a <  b);
               3'd7: z = (a >= b);
               default: z = 1'b0;
            endcase
         end
         2'b10: begin
            case (f3)
               3'd0: r = (ins[30] && !imm) ? a - b : a + b;
               3'd1: r = a << sh;
               3'd2: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
               3'd3: r = {{(XLEN-1){1'b0}}, a < b};
               3'd4: r = a ^ b;
               3'd5: r = ins[30] ? XLEN'($signed(a) >>> sh) : a >> sh;
               3'd6: r = a | b;
               default: r = a & b;
            endcase
            z = (r == '0);
         end
         default: begin
            r = a + b;
            z = (r == '0);
         end
      endcase
      return {z, r};
   endfunction

   assign {alu_zero[0], alu_result[0]} = alu_model(alu_op[0], alu_instr[0], alu_d1[0], alu_d2[0], alu_imm[0]);
   assign {alu_zero[1], alu_result[1]} = alu_model(alu_op[1], alu_instr[1], alu_d1[1], alu_d2[1], alu_imm[1]);

   // Expected response {err, zero, result} from the ALUOp masking rules.
   function automatic logic [XLEN+1:0] exp_resp(input op_t o);
      logic [XLEN:0] m;
      m = alu_model(o.aluop, o.ins, o.a, o.b, o.imm);
      case (o.aluop)
         2'b00, 2'b10: return {1'b0, 1'b0, m[XLEN-1:0]};
         2'b01:        return {1'b0, m[XLEN], {XLEN{1'b0}}};
         default:      return {1'b1, 1'b0, {XLEN{1'b0}}};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int d, input int r, input op_t o);
      v_aluop[d][r] = o.aluop;
      v_instr[d][r] = o.ins;
      v_a[d][r]     = o.a;
      v_b[d][r]     = o.b;
      v_imm[d][r]   = o.imm;
   endtask

   task automatic chk_alu_zero(input int d, input string tag);
      chk({tag, "_alu"}, {alu_op[d], alu_imm[d], alu_instr[d], alu_d1[d] | alu_d2[d]}, 64'd0);
   endtask

   // One full operation starting at a negedge in IDLE; returns at a negedge in IDLE.
   task automatic run_op(input int d, input logic [1:0] vm, input op_t o0, input op_t o1,
                         input int stall, input string tag);
      int              g;
      op_t             o;
      logic [XLEN+1:0] e;
      set_req(d, 0, o0);
      set_req(d, 1, o1);
      v_valid[d] = vm;
      if (vm == 2'b11) g = (d == 1 || last_g[d] == 1) ? 0 : 1;
      else             g = vm[1] ? 1 : 0;
      o = (g == 1) ? o1 : o0;
      e = exp_resp(o);
      #1;
      chk({tag, "_req_ready"}, o_req_ready[d], 64'(2'b01 << g));
      @(negedge clk);
      v_valid[d] = 2'b00;
      last_g[d]  = g;
      chk({tag, "_exec_busy"}, busy_w[d], 1);
      chk({tag, "_exec_gid"}, gid_w[d], g);
      chk({tag, "_exec_ready"}, o_req_ready[d], 0);
      if (o.aluop == 2'b11) begin
         chk_alu_zero(d, {tag, "_ill"});
      end else begin
         chk({tag, "_alu_d1"}, alu_d1[d], o.a);
         chk({tag, "_alu_d2"}, alu_d2[d], o.b);
         chk({tag, "_alu_ctl"}, {alu_op[d], alu_imm[d], alu_instr[d]}, {o.aluop, o.imm, o.ins});
      end
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         chk({tag, "_resp_valid"}, o_resp_valid[d], 64'(2'b01 << g));
         chk({tag, "_resp_fields"}, {o_err[d], o_zero[d], o_result[d]}, e);
         chk({tag, "_resp_busy"}, {busy_w[d], o_req_ready[d]}, 3'b100);
         chk_alu_zero(d, {tag, "_resp"});
         if (s < stall) begin
            v_rready[d] = ~(2'b01 << g);
            @(negedge clk);
         end
      end
      v_rready[d] = 2'b01 << g;
      @(negedge clk);
      v_rready[d] = 2'b00;
      chk({tag, "_done"}, {busy_w[d], o_resp_valid[d]}, 3'b000);
   endtask

   op_t o_sub, o_beq, o_bne, o_ill, o_add, ra, rb;

   initial begin
      for (int d = 0; d < 2; d++) begin
         v_valid[d] = '0; v_rready[d] = '0; v_aluop[d] = '0; v_instr[d] = '0;
         v_a[d] = '0; v_b[d] = '0; v_imm[d] = '0;
         last_g[d] = 1;
      end
      o_sub = '{aluop: 2'b10, ins: 32'h4000_0033, a: 32'd10, b: 32'd3, imm: 1'b0};
      o_beq = '{aluop: 2'b01, ins: 32'h0000_0063, a: 32'd5,  b: 32'd5, imm: 1'b0};
      o_bne = '{aluop: 2'b01, ins: 32'h0000_0063, a: 32'd5,  b: 32'd6, imm: 1'b0};
      o_ill = '{aluop: 2'b11, ins: 32'h0001_2345, a: 32'hDEAD_BEEF, b: 32'h1234_5678, imm: 1'b1};
      o_add = '{aluop: 2'b00, ins: 32'h0000_0013, a: 32'h100, b: 32'h23, imm: 1'b1};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_ctl", {busy_w[d], gid_w[d], o_req_ready[d], o_resp_valid[d]}, 0);
         chk("reset_resp", {o_err[d], o_zero[d], o_result[d]}, 0);
         chk_alu_zero(d, "reset");
      end

      run_op(0, 2'b01, o_sub, o_add, 0, "sub");
      run_op(0, 2'b01, o_beq, o_add, 0, "beq");
      run_op(0, 2'b01, o_bne, o_add, 0, "bne");
      run_op(0, 2'b10, o_add, o_sub, 1, "req1_sub");
      run_op(0, 2'b01, o_ill, o_add, 5, "illegal");

      // Both requesters valid continuously, responses always accepted.
      for (int d = 0; d < 2; d++) begin
         int g;
         set_req(d, 0, o_sub);
         set_req(d, 1, o_add);
         v_valid[d]  = 2'b11;
         v_rready[d] = 2'b11;
         for (int k = 0; k < 4; k++) begin
            g = (d == 1 || last_g[d] == 1) ? 0 : 1;
            last_g[d] = g;
            #1;
            chk("fair_ready", o_req_ready[d], 64'(2'b01 << g));
            @(negedge clk);
            chk("fair_exec", {busy_w[d], gid_w[d], o_req_ready[d]}, {1'b1, g[0], 2'b00});
            @(negedge clk);
            chk("fair_resp", {o_resp_valid[d], o_req_ready[d]}, {2'b01 << g, 2'b00});
            @(negedge clk);
            chk("fair_idle", busy_w[d], 0);
            if (k == 3) v_valid[d] = 2'b00;
         end
         v_rready[d] = 2'b00;
      end

      // Reset during EXEC drops the operation and restores last_grant.
      set_req(0, 0, o_add);
      v_valid[0] = 2'b01;
      @(negedge clk);
      v_valid[0] = 2'b00;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_exec_ctl", {busy_w[0], gid_w[0], o_req_ready[0], o_resp_valid[0]}, 0);
      chk("rst_exec_resp", {o_err[0], o_zero[0], o_result[0]}, 0);
      chk_alu_zero(0, "rst_exec");
      last_g[0] = 1;
      last_g[1] = 1;
      for (int i = 0; i < 3; i++) begin
         v_rready[0] = 2'b11;
         @(negedge clk);
         chk("rst_no_resp", {busy_w[0], o_resp_valid[0]}, 0);
      end
      v_rready[0] = 2'b00;
      run_op(0, 2'b11, o_sub, o_add, 0, "post_rst");

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 25; n++) begin
            ra.aluop = 2'($urandom_range(0, 3));
            ra.ins   = $urandom;
            ra.a     = $urandom;
            ra.b     = ($urandom_range(0, 3) == 0) ? ra.a : $urandom;
            ra.imm   = 1'($urandom_range(0, 1));
            rb.aluop = 2'($urandom_range(0, 3));
            rb.ins   = $urandom;
            rb.a     = $urandom_range(0, 7);
            rb.b     = $urandom_range(0, 7);
            rb.imm   = 1'($urandom_range(0, 1));
            run_op(d, 2'($urandom_range(1, 3)), ra, rb, $urandom_range(0, 2), "rand");
            repeat ($urandom_range(0, 1)) @(negedge clk);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
